// File: rtl/jogo_pkg.sv
// jogo_pkg: shared 4-bit state codes for the memory-game control unit, displays and benches
package jogo_pkg;
  localparam logic [3:0] ST_INICIAL        = 4'h0;
  localparam logic [3:0] ST_PREPARACAO     = 4'h1;
  localparam logic [3:0] ST_INICIA_RODADA  = 4'h2;
  localparam logic [3:0] ST_ESPERA_JOGADA  = 4'h3;
  localparam logic [3:0] ST_REGISTRA       = 4'h4;
  localparam logic [3:0] ST_COMPARACAO     = 4'h5;
  localparam logic [3:0] ST_PROXIMA_JOGADA = 4'h6;
  localparam logic [3:0] ST_PROXIMA_RODADA = 4'h7;
  localparam logic [3:0] ST_FIM_ACERTOU    = 4'hA;
  localparam logic [3:0] ST_FIM_TIMEOUT    = 4'hD;
  localparam logic [3:0] ST_FIM_ERROU      = 4'hE;
  typedef enum logic [3:0] {
    INICIAL        = ST_INICIAL,
    PREPARACAO     = ST_PREPARACAO,
    INICIA_RODADA  = ST_INICIA_RODADA,
    ESPERA_JOGADA  = ST_ESPERA_JOGADA,
    REGISTRA       = ST_REGISTRA,
    COMPARACAO     = ST_COMPARACAO,
    PROXIMA_JOGADA = ST_PROXIMA_JOGADA,
    PROXIMA_RODADA = ST_PROXIMA_RODADA,
    FIM_ACERTOU    = ST_FIM_ACERTOU,
    FIM_TIMEOUT    = ST_FIM_TIMEOUT,
    FIM_ERROU      = ST_FIM_ERROU
  } estado_t;
endpackage

// File: rtl/unidade_controle_jogo.sv
// unidade_controle_jogo: Moore control FSM for the memory-sequence game.
// Define TIMEOUT_EN to enable the jogada timeout (contaT, FIM_TIMEOUT, timeout).
module unidade_controle_jogo
  import jogo_pkg::*;
#(
  parameter bit ZERA_T_POR_JOGADA = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       fimE,
  input  logic       fimRod,
  input  logic       fimT,
  input  logic       igual,
  input  logic       enderecoIgualRodada,
  input  logic       jogada_feita,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraRod,
  output logic       contaRod,
  output logic       zeraT,
  output logic       contaT,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);
`ifdef TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  estado_t estado_q, estado_d;
  logic unused_fim_e;
  assign unused_fim_e = fimE;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado_q <= INICIAL;
    else       estado_q <= estado_d;
  end
  always_comb begin
    estado_d = INICIAL;
    case (estado_q)
      INICIAL:        estado_d = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:     estado_d = INICIA_RODADA;
      INICIA_RODADA:  estado_d = ESPERA_JOGADA;
      ESPERA_JOGADA:  estado_d = jogada_feita ? REGISTRA : (TO_EN && fimT) ? FIM_TIMEOUT : ESPERA_JOGADA;
      REGISTRA:       estado_d = COMPARACAO;
      // a mismatch dominates; the last rodada only matters once the address reached it
      COMPARACAO:     estado_d = !igual ? FIM_ERROU : !enderecoIgualRodada ? PROXIMA_JOGADA :
                                 fimRod ? FIM_ACERTOU : PROXIMA_RODADA;
      PROXIMA_JOGADA: estado_d = ESPERA_JOGADA;
      PROXIMA_RODADA: estado_d = INICIA_RODADA;
      FIM_ACERTOU,
      FIM_ERROU,
      FIM_TIMEOUT:    estado_d = iniciar ? PREPARACAO : estado_q;
      default:        estado_d = INICIAL;
    endcase
  end
  always_comb begin
    zeraE     = estado_q == PREPARACAO || estado_q == INICIA_RODADA;
    contaE    = estado_q == PROXIMA_JOGADA;
    zeraRod   = estado_q == PREPARACAO;
    contaRod  = estado_q == PROXIMA_RODADA;
    zeraT     = estado_q == PREPARACAO || estado_q == INICIA_RODADA ||
                (ZERA_T_POR_JOGADA && estado_q == PROXIMA_JOGADA);
    contaT    = TO_EN && estado_q == ESPERA_JOGADA;
    zeraR     = estado_q == PREPARACAO;
    registraR = estado_q == REGISTRA;
    acertou   = estado_q == FIM_ACERTOU;
    errou     = estado_q == FIM_ERROU;
    timeout   = TO_EN && estado_q == FIM_TIMEOUT;
    pronto    = acertou || errou || estado_q == FIM_TIMEOUT;
  end
  assign db_estado = estado_q;
endmodule

// File: tb/tb_unidade_controle_jogo.sv
// tb_unidade_controle_jogo: scoreboard bench, expected next-state codes queued by stimulus, checked by a monitor.
module tb_unidade_controle_jogo;
  import jogo_pkg::*;
`ifdef TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif
  localparam logic [5:0] NONE = 6'b000000, INI = 6'b100000, FT = 6'b010000, IG = 6'b001000,
                         EQ = 6'b000100, JF = 6'b000010, FR = 6'b000001;
  logic clk = 1'b0, rst = 1'b1;
  logic iniciar = 0, fimT = 0, igual = 0, endig = 0, jogada = 0, fimRod = 0;
  logic [11:0] o0, o1;
  logic [3:0] db0, db1;
  logic [3:0] q[$];
  int vectors = 0, errors = 0, rod_pulses = 0;
  always #5 clk = ~clk;
  unidade_controle_jogo #(.ZERA_T_POR_JOGADA(1'b1)) u0 (
    .clock(clk), .reset(rst), .iniciar(iniciar), .fimE(1'b0), .fimRod(fimRod), .fimT(fimT),
    .igual(igual), .enderecoIgualRodada(endig), .jogada_feita(jogada),
    .zeraE(o0[11]), .contaE(o0[10]), .zeraRod(o0[9]), .contaRod(o0[8]), .zeraT(o0[7]),
    .contaT(o0[6]), .zeraR(o0[5]), .registraR(o0[4]), .pronto(o0[3]), .acertou(o0[2]),
    .errou(o0[1]), .timeout(o0[0]), .db_estado(db0));
  unidade_controle_jogo #(.ZERA_T_POR_JOGADA(1'b0)) u1 (
    .clock(clk), .reset(rst), .iniciar(iniciar), .fimE(1'b0), .fimRod(fimRod), .fimT(fimT),
    .igual(igual), .enderecoIgualRodada(endig), .jogada_feita(jogada),
    .zeraE(o1[11]), .contaE(o1[10]), .zeraRod(o1[9]), .contaRod(o1[8]), .zeraT(o1[7]),
    .contaT(o1[6]), .zeraR(o1[5]), .registraR(o1[4]), .pronto(o1[3]), .acertou(o1[2]),
    .errou(o1[1]), .timeout(o1[0]), .db_estado(db1));
  // {zeraE,contaE,zeraRod,contaRod,zeraT,contaT,zeraR,registraR,pronto,acertou,errou,timeout}
  function automatic logic [11:0] outs(input logic [3:0] s, input bit zt);
    case (s)
      4'h1:    return 12'b1010_1010_0000;
      4'h2:    return 12'b1000_1000_0000;
      4'h3:    return TO ? 12'b0000_0100_0000 : 12'b0;
      4'h4:    return 12'b0000_0001_0000;
      4'h6:    return zt ? 12'b0100_1000_0000 : 12'b0100_0000_0000;
      4'h7:    return 12'b0001_0000_0000;
      4'hA:    return 12'b0000_0000_1100;
      4'hE:    return 12'b0000_0000_1010;
      4'hD:    return TO ? 12'b0000_0000_1001 : 12'b0000_0000_1000;
      default: return 12'b0;
    endcase
  endfunction
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      logic [3:0] e;
      e = q.pop_front();
      check("u0 state/outs", {db0, o0}, {e, outs(e, 1'b1)});
      check("u1 state/outs", {db1, o1}, {e, outs(e, 1'b0)});
    end
  end
  always @(posedge clk) begin
    #1;
    if (o0[8] === 1'b1) rod_pulses++;
  end
  task automatic step(input logic [5:0] in, input logic [3:0] ex);
    @(negedge clk);
    {iniciar, fimT, igual, endig, jogada, fimRod} = in;
    q.push_back(ex);
    @(posedge clk);
  endtask
  task automatic start();
    step(INI, 4'h1);
    step(NONE, 4'h2);
    step(NONE, 4'h3);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset state", {db0, o0}, 16'h0);
    step(NONE, 4'h0);
    // full game, 16 correct rodadas
    start();
    for (int r = 0; r < 16; r++)
      for (int a = 0; a <= r; a++) begin
        step(JF, 4'h4);
        step(NONE, 4'h5);
        if (a < r) begin
          step(IG | (r == 15 ? FR : NONE), 4'h6);
          step(NONE, 4'h3);
        end else if (r < 15) begin
          step(IG | EQ, 4'h7);
          step(NONE, 4'h2);
          step(NONE, 4'h3);
        end else step(IG | EQ | FR, 4'hA);
      end
    step(NONE, 4'hA);
    check("contaRod pulses", 16'(rod_pulses), 16'd15);
    // error at rodada 2, second jogada; iniciar outside INICIAL/FIM is ignored
    start();
    step(INI | JF, 4'h4); step(NONE, 4'h5); step(IG | EQ, 4'h7); step(NONE, 4'h2); step(NONE, 4'h3);
    step(JF, 4'h4); step(INI, 4'h5); step(IG, 4'h6); step(NONE, 4'h3);
    step(JF, 4'h4); step(NONE, 4'h5); step(IG | EQ, 4'h7); step(NONE, 4'h2); step(NONE, 4'h3);
    step(JF, 4'h4); step(NONE, 4'h5); step(IG, 4'h6); step(NONE, 4'h3);
    step(JF, 4'h4); step(NONE, 4'h5); step(EQ, 4'hE); step(NONE, 4'hE);
    // asynchronous reset mid ESPERA_JOGADA
    start();
    #3 rst = 1'b1;
    #1 check("async reset", {db0, o0}, 16'h0);
    check("async reset u1", {db1, o1}, 16'h0);
    @(negedge clk) rst = 1'b0;
    step(NONE, 4'h0);
    // jogada beats fimT
    start();
    step(JF | FT, 4'h4); step(NONE, 4'h5); step(IG | EQ, 4'h7); step(NONE, 4'h2); step(NONE, 4'h3);
    // timeout, or ignored fimT when the feature is compiled out
    step(FT, TO ? 4'hD : 4'h3);
    step(NONE, TO ? 4'hD : 4'h3);
    step(INI, TO ? 4'h1 : 4'h3);
    repeat (2) @(posedge clk);
    #2 check("scoreboard drained", 16'(q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/unidade_controle_jogo.md
Name: unidade_controle_jogo

Overview:
Moore FSM control unit for the memory-sequence game. It consumes the datapath status flags (fimE, fimRod, fimT, igual, enderecoIgualRodada, jogada_feita). It drives every datapath control strobe: counter zero/count, timer, and register enable. It also reports the game outcome (acertou, errou, timeout) and exposes its state for the debug displays.

Parameters:
ZERA_T_POR_JOGADA, 1, 1 = timeout timer restarts after every correct jogada; 0 = timer restarts only at the start of each rodada.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; forces state INICIAL
iniciar  input  1  start/restart request, level-sampled
fimE  input  1  address counter terminal count (unused for transitions, kept for debug)
fimRod  input  1  rodada counter at last rodada (15)
fimT  input  1  timeout counter expired
igual  input  1  stored jogada equals memory word
enderecoIgualRodada  input  1  address counter == rodada counter
jogada_feita  input  1  one-cycle pulse, new key pressed
zeraE, contaE  output  1 each  address counter clear / count
zeraRod, contaRod  output  1 each  rodada counter clear / count (zeraRod also resets the edge detector)
zeraT, contaT  output  1 each  timer clear / count
zeraR, registraR  output  1 each  jogada register clear / load
pronto  output  1  game finished
acertou, errou, timeout  output  1 each  outcome flags
db_estado  output  4  current state code

Behaviour:
- Single clock domain, Moore outputs decoded from the registered state only; one state transition per clock.
- Reset (async, active-high): state = INICIAL; all outputs 0; db_estado = 0x0.
- State codes and outputs (any output not listed is 0):
  - INICIAL 0x0: outputs none. iniciar -> PREPARACAO.
  - PREPARACAO 0x1: zeraE, zeraRod, zeraT, zeraR. -> INICIA_RODADA.
  - INICIA_RODADA 0x2: zeraE, zeraT. -> ESPERA_JOGADA.
  - ESPERA_JOGADA 0x3: contaT. jogada_feita -> REGISTRA; else fimT -> FIM_TIMEOUT; else stay.
  - REGISTRA 0x4: registraR. -> COMPARACAO.
  - COMPARACAO 0x5: no strobes. Transitions, in priority order:
    - !igual -> FIM_ERROU;
    - igual & enderecoIgualRodada & fimRod -> FIM_ACERTOU;
    - igual & enderecoIgualRodada -> PROXIMA_RODADA;
    - otherwise -> PROXIMA_JOGADA.
  - PROXIMA_JOGADA 0x6: contaE, plus zeraT when ZERA_T_POR_JOGADA = 1. -> ESPERA_JOGADA.
  - PROXIMA_RODADA 0x7: contaRod. -> INICIA_RODADA.
  - FIM_ACERTOU 0xA: pronto, acertou. iniciar -> PREPARACAO; else hold.
  - FIM_ERROU 0xE: pronto, errou. iniciar -> PREPARACAO; else hold.
  - FIM_TIMEOUT 0xD: pronto, timeout. iniciar -> PREPARACAO; else hold.
  - Unused codes -> INICIAL next cycle, outputs 0.
- Simultaneous events:
  - jogada_feita and fimT in the same cycle: jogada wins.
  - iniciar is ignored in every state except INICIAL and the FIM_* states.
- Latency:
  - From the jogada_feita pulse: registraR asserts 1 cycle later; the compare decision is taken the cycle after that.
  - Counter strobes are single-cycle pulses, because each strobe-owning state lasts exactly one cycle.
- Outcome flags hold until the FIM_* state is left; PREPARACAO clears them.
- Reset mid-game: immediate return to INICIAL; datapath registers are only cleared on the next PREPARACAO.

Optional Feature:
TIMEOUT_EN
- Defined: behaviour as above.
- Not defined:
  - ESPERA_JOGADA ignores fimT;
  - contaT is tied 0;
  - FIM_TIMEOUT is unreachable;
  - the timeout output is constant 0.

Decomposition:
- Shared package jogo_pkg: 4-bit state code localparams (INICIAL..FIM_TIMEOUT) so display decoders and benches use the same codes.
- No sub-module: a single always block for the state register plus a next-state/output decode.

Test Plan:
1. reset pulse mid-ESPERA_JOGADA -> db_estado = 0x0 immediately, all strobes 0.
2. iniciar, then correct jogadas for rodadas 0..15 (igual = 1, enderecoIgualRodada at address = rodada, fimRod at rodada 15) -> ends in 0xA with pronto = 1, acertou = 1; contaRod pulsed 15 times.
3. Rodada 2, second jogada with igual = 0 -> path 0x4 -> 0x5 -> 0xE; errou = 1, pronto = 1.
4. In 0x3, fimT = 1 with no jogada (TIMEOUT_EN defined) -> 0xD, timeout = 1. Same stimulus without the macro -> state stays 0x3, contaT = 0.
5. jogada_feita and fimT asserted in the same cycle -> next state 0x4, not 0xD.
6. ZERA_T_POR_JOGADA = 0: correct jogada not ending the rodada -> in 0x6 contaE = 1, zeraT = 0. With value 1 -> zeraT = 1 in 0x6.
